// File: rtl/pipe_scroller.sv
// pipe_scroller: scrolls one pipe left per frame tick, respawns it with an LFSR gap, counts pipes passed
//   in  Clk, reset (async active-low), Start, Ack, Freeze
//   out X_Edge_Left/Right, Y_Edge_Top/Bottom [9:0], Score [7:0], Frame_Tick, Q_Idle, Q_Scroll, Q_Halt
module pipe_scroller #(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W = 60,
  parameter int GAP_H = 120,
  parameter int GAP_MIN_Y = 40,
  parameter int SPEED = 2,
  parameter int TICK_DIV = 416667,
  parameter int BIRD_X = 200,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic       Freeze,
  output logic [9:0] X_Edge_Left,
  output logic [9:0] X_Edge_Right,
  output logic [9:0] Y_Edge_Top,
  output logic [9:0] Y_Edge_Bottom,
  output logic [7:0] Score,
  output logic       Frame_Tick,
  output logic       Q_Idle,
  output logic       Q_Scroll,
  output logic       Q_Halt
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [9:0] PARK_L = 10'(SCREEN_W);
  localparam logic [9:0] PARK_R = 10'(SCREEN_W + PIPE_W);
  localparam logic [9:0] PARK_T = 10'(GAP_MIN_Y);
  localparam logic [9:0] PARK_B = 10'(GAP_MIN_Y + GAP_H);
  localparam logic [9:0] STEP = 10'(SPEED);
  typedef enum logic [1:0] {IDLE, SCROLL, RESPAWN, HALT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] tick_cnt;
  logic [15:0] lfsr;
  logic scored;
  logic [9:0] gap_top, new_right;
  assign gap_top = PARK_T + {2'b00, lfsr[7:0]};
  assign new_right = X_Edge_Right - STEP;
  assign Q_Idle = state == IDLE;
  assign Q_Scroll = state == SCROLL || state == RESPAWN;
  assign Q_Halt = state == HALT;
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = Start ? SCROLL : IDLE;
      SCROLL:  state_nxt = Freeze ? HALT : (Frame_Tick && X_Edge_Right <= STEP) ? RESPAWN : SCROLL;
      RESPAWN: state_nxt = SCROLL;
      HALT:    state_nxt = Ack ? IDLE : HALT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      tick_cnt <= '0;
      Frame_Tick <= 1'b0;
      lfsr <= LFSR_SEED;
      scored <= 1'b0;
      Score <= '0;
      X_Edge_Left <= PARK_L;
      X_Edge_Right <= PARK_R;
      Y_Edge_Top <= PARK_T;
      Y_Edge_Bottom <= PARK_B;
    end else begin
      state <= state_nxt;
      tick_cnt <= tick_cnt == CW'(TICK_DIV - 1) ? '0 : tick_cnt + 1'b1;
      Frame_Tick <= tick_cnt == CW'(TICK_DIV - 1);
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      case (state)
        IDLE: begin
          X_Edge_Left <= PARK_L;
          X_Edge_Right <= PARK_R;
          Y_Edge_Top <= Start ? gap_top : PARK_T;
          Y_Edge_Bottom <= Start ? gap_top + 10'(GAP_H) : PARK_B;
          if (Start) begin
            Score <= '0;
            scored <= 1'b0;
          end
        end
        SCROLL: begin
          // A right edge at or below SPEED respawns instead of moving, so the subtraction never wraps
          if (!Freeze && Frame_Tick && X_Edge_Right > STEP) begin
            X_Edge_Left <= X_Edge_Left - STEP;
            X_Edge_Right <= new_right;
            if (!scored && new_right < 10'(BIRD_X)) begin
              Score <= Score + {7'd0, Score != 8'hFF};
              scored <= 1'b1;
            end
          end
        end
        RESPAWN: begin
          X_Edge_Left <= PARK_L;
          X_Edge_Right <= PARK_R;
          Y_Edge_Top <= gap_top;
          Y_Edge_Bottom <= gap_top + 10'(GAP_H);
          scored <= 1'b0;
        end
        HALT: begin
          if (Ack) begin
            X_Edge_Left <= PARK_L;
            X_Edge_Right <= PARK_R;
            Y_Edge_Top <= PARK_T;
            Y_Edge_Bottom <= PARK_B;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_scroller.sv
// tb_pipe_scroller: directed self-checking bench for pipe_scroller
module tb_pipe_scroller;
  logic Clk = 0, reset = 0, Start = 0, Ack = 0, Freeze = 0, start_s = 0;
  logic [9:0] xl, xr, yt, yb, s_xl, s_xr, s_yt, s_yb;
  logic [7:0] score, s_score;
  logic ft, q_idle, q_scroll, q_halt, s_ft, s_idle, s_scroll, s_halt;
  logic [15:0] m_lfsr;
  logic [7:0] ft_bits;
  int checks = 0, failures = 0;
  int exp_top;
  always #5 Clk = ~Clk;
  always @(posedge Clk or negedge reset)
    m_lfsr <= !reset ? 16'hACE1 : ({1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000));
  pipe_scroller #(.TICK_DIV(4)) dut (
    .Clk(Clk), .reset(reset), .Start(Start), .Ack(Ack), .Freeze(Freeze),
    .X_Edge_Left(xl), .X_Edge_Right(xr), .Y_Edge_Top(yt), .Y_Edge_Bottom(yb),
    .Score(score), .Frame_Tick(ft), .Q_Idle(q_idle), .Q_Scroll(q_scroll), .Q_Halt(q_halt)
  );
  pipe_scroller #(.TICK_DIV(2), .SPEED(100)) dut_sat (
    .Clk(Clk), .reset(reset), .Start(start_s), .Ack(1'b0), .Freeze(1'b0),
    .X_Edge_Left(s_xl), .X_Edge_Right(s_xr), .Y_Edge_Top(s_yt), .Y_Edge_Bottom(s_yb),
    .Score(s_score), .Frame_Tick(s_ft), .Q_Idle(s_idle), .Q_Scroll(s_scroll), .Q_Halt(s_halt)
  );
  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  task automatic find_tick();
    for (int i = 0; i < 8 && !ft; i++) @(negedge Clk);
    if (!ft) check("tick_timeout", ft, 1);
  endtask
  task automatic wait_tick();
    find_tick();
    @(negedge Clk);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge Clk);
    check("rst_xl", xl, 640);
    check("rst_xr", xr, 700);
    check("rst_yt", yt, 40);
    check("rst_yb", yb, 160);
    check("rst_score", score, 0);
    check("rst_idle", q_idle, 1);
    check("rst_ft", ft, 0);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      ft_bits[i] = ft;
    end
    check("ft_pattern", ft_bits, 8'h88);
    Start = 1;
    exp_top = 40 + int'(m_lfsr[7:0]);
    @(negedge Clk);
    Start = 0;
    check("start_scroll", q_scroll, 1);
    check("start_yt", yt, exp_top);
    check("start_yb", yb, exp_top + 120);
    check("start_xl", xl, 640);
    repeat (10) wait_tick();
    check("tick10_xl", xl, 620);
    check("tick10_xr", xr, 680);
    for (int i = 0; i < 300 && xr > 200; i++) wait_tick();
    check("pre_bird_xr", xr, 200);
    check("pre_bird_score", score, 0);
    wait_tick();
    check("bird_xr", xr, 198);
    check("bird_score", score, 1);
    for (int i = 0; i < 120 && xr > 2; i++) wait_tick();
    check("edge2_xr", xr, 2);
    check("edge2_score", score, 1);
    find_tick();
    @(negedge Clk);
    check("respawn_xr", xr, 2);
    check("respawn_qscroll", q_scroll, 1);
    exp_top = 40 + int'(m_lfsr[7:0]);
    @(negedge Clk);
    check("new_xl", xl, 640);
    check("new_xr", xr, 700);
    check("new_yt", yt, exp_top);
    check("new_yb", yb, exp_top + 120);
    for (int i = 0; i < 300 && xr > 198; i++) wait_tick();
    check("second_pipe_score", score, 2);
    find_tick();
    Freeze = 1;
    @(negedge Clk);
    Freeze = 0;
    check("freeze_halt", q_halt, 1);
    check("freeze_xl", xl, 138);
    check("freeze_xr", xr, 198);
    Start = 1;
    repeat (8) @(negedge Clk);
    Start = 0;
    check("halt_held", q_halt, 1);
    check("halt_xl", xl, 138);
    check("halt_score", score, 2);
    Ack = 1;
    @(negedge Clk);
    Ack = 0;
    check("ack_idle", q_idle, 1);
    check("ack_xl", xl, 640);
    check("ack_xr", xr, 700);
    check("ack_yt", yt, 40);
    check("ack_yb", yb, 160);
    check("ack_score", score, 2);
    Start = 1;
    @(negedge Clk);
    Start = 0;
    check("restart_score", score, 0);
    repeat (3) wait_tick();
    check("run3_xl", xl, 634);
    #2 reset = 0;
    #1;
    check("midrst_xl", xl, 640);
    check("midrst_xr", xr, 700);
    check("midrst_yt", yt, 40);
    check("midrst_idle", q_idle, 1);
    check("midrst_ft", ft, 0);
    @(negedge Clk);
    reset = 1;
    @(negedge Clk);
    start_s = 1;
    @(negedge Clk);
    start_s = 0;
    for (int i = 0; i < 8000 && s_score != 8'd255; i++) @(negedge Clk);
    check("sat_reach", s_score, 255);
    repeat (200) @(negedge Clk);
    check("sat_hold", s_score, 255);
    check("sat_scroll", s_scroll, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
